// File: rtl/lpf_stream_buffer_pkg.sv
// Shared constants and types for the low-pass-filter stream buffer.
// Frame geometry defaults mirror the filter's raster; the state type is used only by the top.
package lpf_stream_buffer_pkg;

  localparam int LOG_TRUNC  = 8;   // filtered pixel width
  localparam int LOG_WIDTH  = 10;  // column coordinate width
  localparam int LOG_HEIGHT = 9;   // row coordinate width
  localparam int ISSUED_W   = 19;  // request counter width, holds a full frame

  localparam int IMAGE_WIDTH_DEF  = 640;
  localparam int IMAGE_HEIGHT_DEF = 480;

  function automatic logic [ISSUED_W-1:0] frame_pixels(input int width, input int height);
    return ISSUED_W'(width * height);
  endfunction

  localparam logic [ISSUED_W-1:0] FRAME_PIXELS = frame_pixels(IMAGE_WIDTH_DEF, IMAGE_HEIGHT_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/lpf_sync_fifo.sv
// Synchronous FIFO whose head entry is held in a register, so readers see registered data.
// A push into an empty FIFO is visible at the head one cycle later; flush empties it in one cycle.
module lpf_sync_fifo #(
  parameter int DEPTH     = 8,
  parameter int LOG_DEPTH = 3,
  parameter int WIDTH     = 27
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     wr_data,
  output logic [WIDTH-1:0]     head_data,
  output logic                 full,
  output logic                 empty,
  output logic [LOG_DEPTH:0]   count_next
);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr_next;
  logic [LOG_DEPTH:0]   count;
  logic                 push_ok;
  logic                 pop_ok;

  assign full        = (count == (LOG_DEPTH+1)'(DEPTH));
  assign empty       = (count == '0);
  assign pop_ok      = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok     = push && (!full || pop_ok);
  assign rd_ptr_next = rd_ptr + LOG_DEPTH'(pop_ok);
  assign count_next  = flush ? '0
                     : count + (LOG_DEPTH+1)'(push_ok) - (LOG_DEPTH+1)'(pop_ok);

  // NOTE: storage has no reset; only pointers and count define validity, so resetting it buys nothing.
  always_ff @(posedge clock) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_data <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + LOG_DEPTH'(push_ok);
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      // Bypass the write when the entry being written becomes the new head.
      if (count_next != '0) begin
        head_data <= (push_ok && (wr_ptr == rd_ptr_next)) ? wr_data : mem[rd_ptr_next];
      end
    end
  end

endmodule

// File: rtl/lpf_stream_buffer.sv
// Credit-limited request/return buffer between the low-pass filter and the projective transform.
// Sequences one raster frame per frame_flag and presents pixels on a valid/ready interface.
module lpf_stream_buffer
  import lpf_stream_buffer_pkg::*;
#(
  parameter int DEPTH           = 8,
  parameter int LOG_DEPTH       = 3,
  parameter int MAX_OUTSTANDING = 2,
  parameter int IMAGE_WIDTH     = IMAGE_WIDTH_DEF,
  parameter int IMAGE_HEIGHT    = IMAGE_HEIGHT_DEF,
  parameter int PIX_W           = LOG_TRUNC
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  frame_flag,
  output logic                  request,
  input  logic [PIX_W-1:0]      in_pixel,
  input  logic [LOG_WIDTH-1:0]  in_x,
  input  logic [LOG_HEIGHT-1:0] in_y,
  input  logic                  in_flag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PIX_W-1:0]      out_pixel,
  output logic [LOG_WIDTH-1:0]  out_x,
  output logic [LOG_HEIGHT-1:0] out_y,
  output logic                  out_last,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int FIFO_W = PIX_W + LOG_WIDTH + LOG_HEIGHT;
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ISSUED_W-1:0] FRAME_TARGET = frame_pixels(IMAGE_WIDTH, IMAGE_HEIGHT);

  state_t               state;
  state_t               state_next;
  logic [OUT_W-1:0]     outstanding;
  logic [OUT_W-1:0]     outstanding_base;
  logic [OUT_W-1:0]     discard;
  logic [OUT_W-1:0]     discard_next;
  logic [ISSUED_W-1:0]  issued;
  logic [ISSUED_W-1:0]  issued_next;
  logic                 request_next;
  logic                 frame_done_next;
  logic                 restart;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LOG_DEPTH:0]   count_next;
  logic [FIFO_W-1:0]    head;

  assign restart   = frame_flag && (state != ST_IDLE);
  assign push      = in_flag && (discard == '0);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  lpf_sync_fifo #(
    .DEPTH     (DEPTH),
    .LOG_DEPTH (LOG_DEPTH),
    .WIDTH     (FIFO_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (frame_flag),
    .push       (push),
    .pop        (pop),
    .wr_data    ({in_pixel, in_x, in_y}),
    .head_data  (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count_next (count_next)
  );

  assign out_pixel = head[FIFO_W-1 -: PIX_W];
  assign out_x     = head[LOG_HEIGHT +: LOG_WIDTH];
  assign out_y     = head[LOG_HEIGHT-1:0];
  assign out_last  = out_valid
                  && (out_x == LOG_WIDTH'(IMAGE_WIDTH - 1))
                  && (out_y == LOG_HEIGHT'(IMAGE_HEIGHT - 1));

  // Request decisions use next-cycle occupancy, so the pulse is counted the cycle it is visible.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_next       = state;
    issued_next      = issued;
    discard_next     = discard;
    frame_done_next  = 1'b0;
    outstanding_base = outstanding - OUT_W'(in_flag && (outstanding != '0));

    if (in_flag && (discard != '0)) begin
      discard_next = discard - OUT_W'(1);
    end

    case (state)
      ST_IDLE: begin
        if (frame_flag) begin
          state_next  = ST_RUN;
          issued_next = '0;
        end
      end
      ST_RUN: begin
        if (issued == FRAME_TARGET) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((outstanding == '0) && pop && out_last) begin
          state_next      = ST_IDLE;
          frame_done_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Restart: every return still in flight belongs to the abandoned frame.
    if (restart) begin
      state_next      = ST_RUN;
      issued_next     = '0;
      discard_next    = outstanding_base;
      frame_done_next = 1'b0;
    end

    request_next = (state_next == ST_RUN)
                && (outstanding_base < OUT_W'(MAX_OUTSTANDING))
                && ((int'(count_next) + int'(outstanding_base)) < DEPTH)
                && (issued_next < FRAME_TARGET)
                && (discard_next == '0);

    if (request_next) begin
      issued_next = issued_next + ISSUED_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      outstanding <= '0;
      discard     <= '0;
      issued      <= '0;
      request     <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_next;
      outstanding <= outstanding_base + OUT_W'(request_next);
      discard     <= discard_next;
      issued      <= issued_next;
      request     <= request_next;
      frame_done  <= frame_done_next;
      if (push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lpf_stream_buffer.sv
// Randomized bench: a latency-modelled filter feeds the buffer; a scoreboard of accepted
// returns predicts head contents, valid, last, frame_done and overflow every cycle.
module tb_lpf_stream_buffer;
  import lpf_stream_buffer_pkg::*;

  localparam int W     = 6;
  localparam int H     = 4;
  localparam int DEPTH = 8;
  localparam int MAXO  = 2;
  localparam int PW    = LOG_TRUNC;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  frame_flag = 1'b0;
  logic                  request;
  logic [PW-1:0]         in_pixel = '0;
  logic [LOG_WIDTH-1:0]  in_x = '0;
  logic [LOG_HEIGHT-1:0] in_y = '0;
  logic                  in_flag = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [PW-1:0]         out_pixel;
  logic [LOG_WIDTH-1:0]  out_x;
  logic [LOG_HEIGHT-1:0] out_y;
  logic                  out_last;
  logic                  frame_done;
  logic                  overflow;

  always #5 clock = ~clock;

  lpf_stream_buffer #(
    .DEPTH(DEPTH), .LOG_DEPTH(3), .MAX_OUTSTANDING(MAXO),
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIX_W(PW)
  ) dut (
    .clock(clock), .reset(reset), .frame_flag(frame_flag), .request(request),
    .in_pixel(in_pixel), .in_x(in_x), .in_y(in_y), .in_flag(in_flag),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_x(out_x), .out_y(out_y), .out_last(out_last),
    .frame_done(frame_done), .overflow(overflow)
  );

  typedef struct { int due; int x; int y; int pix; int epoch; } ret_t;
  typedef struct { int x; int y; int pix; } pel_t;

  ret_t filt_q[$];   // requests in flight inside the filter model
  pel_t exp_q[$];    // what the buffer should be holding, head first

  int vectors = 0, miscompares = 0;
  int cyc = 0, epoch = 0, issued = 0, fx = 0, fy = 0, last_due = 0;
  int lat_min = 3, lat_max = 3, ready_mode = 1, done_cnt = 0, pops = 0;
  int first_x = -1, first_y = -1;
  bit active = 0, exp_done = 0, exp_ovf = 0, inject = 0, track_first = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic accept(input int x, input int y, input int pix);
    pel_t p;
    if (exp_q.size() >= DEPTH) begin
      exp_ovf = 1;
    end else begin
      p.x = x; p.y = y; p.pix = pix;
      exp_q.push_back(p);
    end
  endtask

  task automatic tick(input bit ff);
    ret_t r;
    pel_t p;
    bit   legal, old_pending, popped_last;
    int   due;
    @(negedge clock);
    cyc++;
    if (reset) begin
      check("rst_request", request, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_pixel", out_pixel, 0);
      check("rst_out_x", out_x, 0);
      check("rst_out_y", out_y, 0);
      check("rst_out_last", out_last, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_overflow", overflow, 0);
      filt_q.delete(); exp_q.delete();
      exp_done = 0; exp_ovf = 0; active = 0; issued = 0; fx = 0; fy = 0; last_due = 0;
      frame_flag = 0; in_flag = 0; out_ready = 0;
      return;
    end
    if (frame_done === 1'b1) done_cnt++;
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("out_pixel", out_pixel, exp_q[0].pix);
      check("out_x", out_x, exp_q[0].x);
      check("out_y", out_y, exp_q[0].y);
      check("out_last", out_last, (exp_q[0].x == W-1) && (exp_q[0].y == H-1));
    end
    check("frame_done", frame_done, exp_done);
    check("overflow", overflow, exp_ovf);

    old_pending = 0;
    foreach (filt_q[i]) if (filt_q[i].epoch != epoch) old_pending = 1;
    legal = active && (filt_q.size() < MAXO) && (exp_q.size() + filt_q.size() < DEPTH)
         && (issued < W*H) && !old_pending;
    check("req_legal", request && !legal, 0);

    if (request === 1'b1) begin
      due = cyc + $urandom_range(lat_min, lat_max);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      r.due = due; r.x = fx; r.y = fy; r.pix = $urandom_range(0, (1 << PW) - 1); r.epoch = epoch;
      filt_q.push_back(r);
      issued++;
      fx++;
      if (fx == W) begin fx = 0; fy++; end
    end

    frame_flag = ff;
    case (ready_mode)
      0:       out_ready = 0;
      1:       out_ready = 1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase

    popped_last = 0;
    if (out_valid === 1'b1 && out_ready && exp_q.size() != 0) begin
      p = exp_q.pop_front();
      pops++;
      popped_last = (p.x == W-1) && (p.y == H-1);
      if (track_first) begin first_x = p.x; first_y = p.y; track_first = 0; end
    end
    exp_done = popped_last && !ff;

    in_flag = 0;
    if (filt_q.size() != 0 && filt_q[0].due == cyc) begin
      r = filt_q.pop_front();
      in_flag = 1; in_pixel = PW'(r.pix); in_x = LOG_WIDTH'(r.x); in_y = LOG_HEIGHT'(r.y);
      if (!ff && r.epoch == epoch) accept(r.x, r.y, r.pix);
    end else if (inject && !ff && !out_ready && exp_q.size() == DEPTH && !old_pending) begin
      in_flag = 1;
      in_pixel = PW'($urandom); in_x = LOG_WIDTH'($urandom_range(0, W-1)); in_y = LOG_HEIGHT'($urandom_range(0, H-1));
      accept(int'(in_x), int'(in_y), int'(in_pixel));
      inject = 0;
    end

    if (ff) begin
      exp_q.delete(); epoch++; issued = 0; fx = 0; fy = 0; active = 1;
    end
  endtask

  task automatic run_until_done(input int want, input int budget);
    int k = 0;
    while (done_cnt < want && k < budget) begin tick(0); k++; end
    check("frame_done_count", done_cnt, want);
  endtask

  initial begin
    int k;
    repeat (3) tick(0);
    reset = 0;

    // Frame 1: fixed 3-cycle latency, always ready, raster order.
    ready_mode = 1; lat_min = 3; lat_max = 3;
    tick(1);
    tick(0);
    check("req_rise", request, 1);
    run_until_done(1, 400);
    repeat (10) tick(0);
    check("single_done_pulse", done_cnt, 1);

    // Frame 2: downstream stalls long enough to fill the FIFO, then releases.
    tick(1);
    ready_mode = 0;
    repeat (50) tick(0);
    ready_mode = 1; pops = 0;
    repeat (8) tick(0);
    check("burst_pops", pops, 8);
    ready_mode = 2; lat_min = 1; lat_max = 5;
    run_until_done(2, 2000);

    // Frame 3: restart mid-frame with two requests in flight.
    lat_min = 3; lat_max = 4;
    tick(1);
    k = 0;
    while (!(issued >= 6 && filt_q.size() == 2) && k < 500) begin tick(0); k++; end
    check("restart_setup_timeout", k < 500, 1);
    tick(1);
    track_first = 1;
    tick(0);
    check("flush_valid", out_valid, 0);
    run_until_done(3, 2000);
    check("restart_first_x", first_x, 0);
    check("restart_first_y", first_y, 0);

    // Frame 4: nonconforming extra return while full sets sticky overflow.
    lat_min = 2; lat_max = 2;
    tick(1);
    ready_mode = 0;
    k = 0;
    while (!(exp_q.size() == DEPTH && filt_q.size() == 0) && k < 300) begin tick(0); k++; end
    check("fill_timeout", k < 300, 1);
    inject = 1;
    k = 0;
    while (inject && k < 20) begin tick(0); k++; end
    check("inject_timeout", inject, 0);
    repeat (5) tick(0);
    check("overflow_sticky", overflow, 1);
    ready_mode = 2;
    run_until_done(4, 2000);
    check("overflow_held", overflow, 1);
    reset = 1; tick(0); reset = 0;
    tick(0);
    check("overflow_cleared", overflow, 0);

    // Frame 5: reset while draining abandons the frame without frame_done.
    ready_mode = 2; lat_min = 2; lat_max = 4;
    tick(1);
    k = 0;
    while (issued < W*H && k < 500) begin tick(0); k++; end
    check("drain_setup_timeout", issued, W*H);
    ready_mode = 0;
    repeat (3) tick(0);
    reset = 1; tick(0); reset = 0;
    ready_mode = 1;
    repeat (30) tick(0);
    check("no_done_after_reset", done_cnt, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lpf_stream_buffer.md
Name: lpf_stream_buffer

Overview:
- Sits between the low-pass filter read port and projective_transform.
- Issues per-pixel request pulses to the filter and captures returned pixel/x/y on pixel_flag into a small FIFO.
- Presents pixels downstream with a valid/ready handshake, decoupling transform stalls from filter/memory latency.
- Credit-limited so the FIFO can never overflow with a conforming upstream; sequences one raster frame per frame_flag.

Parameters:
- DEPTH, 8, FIFO entries (power of two).
- LOG_DEPTH, 3, log2(DEPTH).
- MAX_OUTSTANDING, 2, maximum requests in flight to the filter.
- IMAGE_WIDTH, 640, pixels per row.
- IMAGE_HEIGHT, 480, rows per frame.
- PIX_W, `LOG_TRUNC, pixel width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_flag  in  1  one-cycle start-of-frame pulse
- request  out  1  one-cycle pulse asking filter for next raster pixel
- in_pixel  in  PIX_W  filtered pixel, valid with in_flag
- in_x  in  10  column of in_pixel
- in_y  in  9  row of in_pixel
- in_flag  in  1  return strobe from filter
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head this cycle
- out_pixel  out  PIX_W  head pixel
- out_x  out  10  head column
- out_y  out  9  head row
- out_last  out  1  head is (IMAGE_WIDTH-1, IMAGE_HEIGHT-1)
- frame_done  out  1  one-cycle pulse after last pixel popped
- overflow  out  1  sticky error: push while FIFO full

Behaviour:
- Reset: request, out_valid, out_pixel, out_x, out_y, out_last, frame_done, overflow = 0. FSM = IDLE. FIFO empty. All counters 0. Reset mid-frame abandons everything; no frame_done.
- Handshakes:
  - Pop occurs when out_valid & out_ready.
  - Push occurs when in_flag & discard==0.
  - out_* are registered from FIFO head. A push into an empty FIFO gives out_valid on the next cycle (1-cycle latency). out_* hold stable while out_valid & !out_ready.
- Counters:
  - outstanding (0..MAX_OUTSTANDING): +1 on request, -1 on in_flag; both in the same cycle leaves it unchanged.
  - count (0..DEPTH): +push, -pop.
  - issued (19 bits): requests issued this frame, target IMAGE_WIDTH*IMAGE_HEIGHT.
- Credit rule: request=1 only in RUN, when outstanding<MAX_OUTSTANDING, count+outstanding<DEPTH and issued<W*H. At most one request per cycle.
- FSM:
  - IDLE: frame_flag -> RUN; clear issued and count/pointers.
  - RUN: issued reaching W*H -> DRAIN.
  - DRAIN: outstanding==0 and the pop of the out_last entry occurs -> pulse frame_done, go to IDLE.
- frame_flag in RUN/DRAIN (restart):
  - Flush FIFO and drop out_valid next cycle.
  - Set discard=outstanding (counting any request issued that cycle) and reset issued; state RUN.
  - in_flag while discard>0 decrements discard and drops the data.
  - No requests are issued until discard==0.
- Boundaries:
  - Push with count==DEPTH and no simultaneous pop: drop data and set overflow; only a nonconforming upstream can cause this.
  - Push and pop both at count==DEPTH: legal, count unchanged.
  - Push and pop both at count==0: data goes to the head register and out_valid=1 next cycle.
  - Pointers wrap mod DEPTH.
- Arithmetic: out_last compares the stored x/y, not a counter. Coordinates pass through unmodified.

Decomposition:
- params.v: IMAGE_WIDTH, IMAGE_HEIGHT, `LOG_TRUNC, `LOG_WIDTH, `LOG_HEIGHT, plus a new `FRAME_PIXELS constant.
- FSM state encodings are local parameters.
- One natural sub-module: lpf_sync_fifo (DEPTH x (PIX_W+19), registered head, full/empty/count outputs, synchronous flush).

Test Plan:
- Reset then frame_flag with a 3-cycle-latency model and out_ready=1:
  - request rises within 1 cycle of frame_flag.
  - Outstanding never exceeds 2.
  - Pixels emerge in raster order (0,0),(1,0)...
- out_ready=0 for 50 cycles:
  - count reaches 8 and holds.
  - request stays 0 and overflow stays 0.
  - On release, 8 pixels pop on consecutive cycles.
- Small frame (W=4, H=2 override), full run:
  - out_last=1 only on (3,1).
  - frame_done pulses exactly once, the cycle after that pop.
  - FSM returns to IDLE and request stays 0.
- frame_flag mid-frame with 2 requests outstanding:
  - The next 2 in_flag returns are dropped.
  - out_valid=0 the cycle after frame_flag.
  - The first emitted pixel is (0,0).
- Model injects an extra in_flag while the FIFO is full: overflow=1 and stays 1 until reset; FIFO contents are unchanged.
- Reset asserted during DRAIN: all outputs 0 next cycle and no frame_done.
